fetch_queue_stage: RTL and testbench

Parametrised instruction-fetch stage. It holds the program counter, drives the instruction-memory address and buffers fetched instructions in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake, so fetch keeps running while decode stalls. An execute-stage redirect flushes the queue and reloads the PC. It sits between the PC/imem logic and the decode stage, replacing the single IF/ID register.

---
 rtl/fetch_queue_stage.sv | 121 ++++++++++++
 tb/tb_fetch_queue_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: PC register, imem address drive and a DEPTH-entry
// fetch queue feeding decode. Optional perf counters under `FETCH_PERF_EN`.
module fetch_queue_stage #(
  parameter int unsigned      XLEN         = 32,
  parameter int unsigned      DEPTH        = 2,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      PC_STEP      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  input  logic            ReadyD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc4_mem_q   [DEPTH];
  logic            has_entry, full, push, pop;
  logic            unused_tgt_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_tgt_bits = ^PCTargetE[1:0];

  assign pc_plus   = pc_q + XLEN'(PC_STEP);
  assign has_entry = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign ValidD    = has_entry & reset;
  assign pop       = ValidD & ReadyD;
  // Gating with reset keeps imem_en low for the whole reset window.
  assign push      = reset & ~PCSrcE & (~full | pop);
  assign imem_en   = push;
  assign imem_addr = pc_q;

  assign InstrD   = ValidD ? instr_mem_q[rd_q] : '0;
  assign PCD      = ValidD ? pc_mem_q[rd_q]    : '0;
  assign PCPlus4D = ValidD ? pc4_mem_q[rd_q]   : '0;

  always_comb begin
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (PCSrcE) begin
      pc_d    = {PCTargetE[XLEN-1:2], 2'b00};
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_plus;
        wr_d = ptr_inc(wr_q);
      end
      if (pop) rd_d = ptr_inc(rd_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VECTOR;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]    <= pc_q;
      instr_mem_q[wr_q] <= imem_rdata;
      pc4_mem_q[wr_q]   <= pc_plus;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (full && !pop && !PCSrcE && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (PCSrcE && has_entry && (flush_q != '1))     flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage (DEPTH=2); imem returns addr+'h100.
module tb_fetch_queue_stage;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        imem_en, ValidD;
  logic        ReadyD = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pc4;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] m_pc = 32'h0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h100;

  fetch_queue_stage #(
    .XLEN(32),
    .DEPTH(DEPTH),
    .RESET_VECTOR(32'h0),
    .PC_STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE),
    .imem_addr(imem_addr),
    .imem_en(imem_en),
    .imem_rdata(imem_rdata),
    .InstrD(InstrD),
    .PCD(PCD),
    .PCPlus4D(PCPlus4D),
    .ValidD(ValidD),
    .ReadyD(ReadyD)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  function automatic logic exp_en();
    return reset && !PCSrcE &&
           ((sb.size() < DEPTH) || ((sb.size() != 0) && ReadyD));
  endfunction

  function automatic logic [96:0] exp_head();
    if (!reset || sb.size() == 0) return '0;
    return {1'b1, sb[0].pc, sb[0].ins, sb[0].pc4};
  endfunction

  // Advances the reference model across the coming rising edge.
  task automatic model_step();
    logic push_m, pop_m;
    ent_t e;
    if (!reset) begin
      sb.delete();
      m_pc = 32'h0;
      return;
    end
    push_m = exp_en();
    pop_m  = (sb.size() != 0) && ReadyD;
    if (PCSrcE) begin
      sb.delete();
      m_pc = {PCTargetE[31:2], 2'b00};
    end else begin
      if (pop_m) void'(sb.pop_front());
      if (push_m) begin
        e.pc  = m_pc;
        e.ins = m_pc + 32'h100;
        e.pc4 = m_pc + 32'd4;
        sb.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if ({ValidD, PCD, InstrD, PCPlus4D} !== 97'd0) begin
      bad++;
      $display("FAIL reset_head got=%h exp=0", {ValidD, PCD, InstrD, PCPlus4D});
    end
    total++;
    if ({imem_addr, imem_en} !== {32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_fetch got=%h/%b exp=0/0", imem_addr, imem_en);
    end
    PCSrcE = 1'b0;
    ReadyD = 1'b1;
    reset  = 1'b1;
    #1;
    total++;
    if ({imem_addr, imem_en} !== {m_pc, exp_en()}) begin
      bad++;
      $display("FAIL release_fetch got=%h/%b exp=%h/%b", imem_addr, imem_en, m_pc, exp_en());
    end
    model_step();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      PCSrcE = 1'b0;
      ReadyD = 1'b1;
      #1;
      total++;
      if ({ValidD, PCD, InstrD, PCPlus4D} !== exp_head()) begin
        bad++;
        $display("FAIL stream_head cyc=%0d got=%h exp=%h", i, {ValidD, PCD, InstrD, PCPlus4D}, exp_head());
      end
      total++;
      if ({imem_addr, imem_en} !== {m_pc, exp_en()}) begin
        bad++;
        $display("FAIL stream_fetch cyc=%0d got=%h/%b exp=%h/%b", i, imem_addr, imem_en, m_pc, exp_en());
      end
      model_step();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      PCSrcE = 1'b0;
      ReadyD = (i >= 5);
      #1;
      total++;
      if ({ValidD, PCD, InstrD, PCPlus4D} !== exp_head()) begin
        bad++;
        $display("FAIL stall_head cyc=%0d got=%h exp=%h", i, {ValidD, PCD, InstrD, PCPlus4D}, exp_head());
      end
      total++;
      if ({imem_addr, imem_en} !== {m_pc, exp_en()}) begin
        bad++;
        $display("FAIL stall_fetch cyc=%0d got=%h/%b exp=%h/%b", i, imem_addr, imem_en, m_pc, exp_en());
      end
      model_step();
    end
  endtask

  task automatic test_redirect(input logic [31:0] tgt, input logic rdy_on_flush);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      PCSrcE    = (i == 3);
      PCTargetE = tgt;
      ReadyD    = (i == 3) ? rdy_on_flush : (i > 3);
      #1;
      total++;
      if ({ValidD, PCD, InstrD, PCPlus4D} !== exp_head()) begin
        bad++;
        $display("FAIL redirect_head tgt=%h cyc=%0d got=%h exp=%h", tgt, i, {ValidD, PCD, InstrD, PCPlus4D}, exp_head());
      end
      total++;
      if ({imem_addr, imem_en} !== {m_pc, exp_en()}) begin
        bad++;
        $display("FAIL redirect_fetch tgt=%h cyc=%0d got=%h/%b exp=%h/%b", tgt, i, imem_addr, imem_en, m_pc, exp_en());
      end
      model_step();
    end
    PCSrcE = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      PCSrcE    = (i == 0);
      PCTargetE = 32'hFFFF_FFFE;
      ReadyD    = (i >= 4);
      #1;
      total++;
      if ({ValidD, PCD, InstrD, PCPlus4D} !== exp_head()) begin
        bad++;
        $display("FAIL wrap_head cyc=%0d got=%h exp=%h", i, {ValidD, PCD, InstrD, PCPlus4D}, exp_head());
      end
      total++;
      if ({imem_addr, imem_en} !== {m_pc, exp_en()}) begin
        bad++;
        $display("FAIL wrap_fetch cyc=%0d got=%h/%b exp=%h/%b", i, imem_addr, imem_en, m_pc, exp_en());
      end
      model_step();
    end
    PCSrcE = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      PCSrcE = 1'b0;
      ReadyD = 1'b0;
      #1;
      model_step();
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({ValidD, PCD, InstrD, PCPlus4D, imem_en} !== 98'd0) begin
      bad++;
      $display("FAIL async_reset_head got=%h exp=0", {ValidD, PCD, InstrD, PCPlus4D, imem_en});
    end
    model_step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset  = 1'b1;
      ReadyD = 1'b1;
      #1;
      total++;
      if ({ValidD, PCD, InstrD, PCPlus4D} !== exp_head()) begin
        bad++;
        $display("FAIL post_reset_head cyc=%0d got=%h exp=%h", i, {ValidD, PCD, InstrD, PCPlus4D}, exp_head());
      end
      total++;
      if ({imem_addr, imem_en} !== {m_pc, exp_en()}) begin
        bad++;
        $display("FAIL post_reset_fetch cyc=%0d got=%h/%b exp=%h/%b", i, imem_addr, imem_en, m_pc, exp_en());
      end
`ifdef FETCH_PERF_EN
      if (i == 0) begin
        total++;
        if ({stall_cycles, flush_count} !== 64'd0) begin
          bad++;
          $display("FAIL perf_cleared got=%h/%h exp=0/0", stall_cycles, flush_count);
        end
      end
`endif
      model_step();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect(32'h0000_0203, 1'b0);
    test_redirect(32'h0000_0040, 1'b1);
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
